// File: rtl/me_schedule.sv
// rtl/me_schedule.sv - sequencer and minimum-SAD tracker for the 1-D systolic motion-estimation array
module me_schedule #(
    parameter int N   = 4,
    parameter int V   = 4,
    parameter int DW  = 16,
    parameter int RAW = $clog2(N*N),
    parameter int SAW = $clog2((N+V-1)*2*N)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [RAW-1:0]       ref_addr,
    output logic [SAW-1:0]       s1_addr,
    output logic [SAW-1:0]       s2_addr,
    output logic [N-1:0]         s1s2_sel,
    output logic [N-1:0]         new_dist,
    output logic [$clog2(N)-1:0] dist_sel,
    input  logic [DW-1:0]        dist_in,
    output logic [$clog2(N)-1:0] best_dx,
    output logic [$clog2(V)-1:0] best_dy,
    output logic [DW-1:0]        best_sad
);
    localparam int CW  = $clog2(N);
    localparam int VW  = $clog2(V+1);
    localparam int DYW = $clog2(V);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, nxt_state;
    logic [CW-1:0]   col, row, nxt_col, nxt_row;
    logic [VW-1:0]   v, nxt_v, v_m1;
    logic [RAW-1:0]  n_ref;
    logic [SAW-1:0]  n_s1, n_s2;
    logic [N-1:0]    n_sel, n_nd;
    logic [CW-1:0]   n_ds;
    logic            capture;
    int              srow;

    always_comb begin
        nxt_state = state;
        nxt_col   = col;
        nxt_row   = row;
        nxt_v     = v;
        case (state)
            IDLE: begin
                if (start) begin
                    nxt_state = RUN;
                    nxt_col   = '0;
                    nxt_row   = '0;
                    nxt_v     = '0;
                end
            end
            RUN: begin
                if (int'(col) == N-1) begin
                    nxt_col = '0;
                    if (int'(row) == N-1) begin
                        // after the last pass v lands on V, which DRAIN uses as-is
                        nxt_row = '0;
                        nxt_v   = v + VW'(1);
                        if (int'(v) == V-1)
                            nxt_state = DRAIN;
                    end else begin
                        nxt_row = row + CW'(1);
                    end
                end else begin
                    nxt_col = col + CW'(1);
                end
            end
            DRAIN: begin
                if (int'(col) == N-1) begin
                    nxt_state = DONE;
                    nxt_col   = '0;
                    nxt_v     = '0;
                end else begin
                    nxt_col = col + CW'(1);
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase

        n_ref = '0;
        n_s1  = '0;
        n_s2  = '0;
        n_sel = '0;
        n_nd  = '0;
        n_ds  = '0;
        srow  = 0;
        if (nxt_state == RUN || nxt_state == DRAIN) begin
            n_ref = RAW'(int'(nxt_row)*N + int'(nxt_col));
            if (nxt_state == RUN)
                n_s1 = SAW'((int'(nxt_row) + int'(nxt_v))*2*N + int'(nxt_col));
            srow = (nxt_row != '0) ? int'(nxt_row) - 1 + int'(nxt_v) : N + int'(nxt_v) - 2;
            if (!(nxt_row == '0 && nxt_v == '0))
                n_s2 = SAW'(srow*2*N + int'(nxt_col) + N);
            for (int k = 0; k < N; k++) begin
                n_sel[k] = int'(nxt_col) < k;
                n_nd[k]  = (nxt_row == '0) && (int'(nxt_col) == k);
            end
            n_ds = nxt_col;
        end
    end

    // row 0 of pass v presents PE col's finished sum for displacement (col, v-1)
    assign v_m1    = v - VW'(1);
    assign capture = (state == RUN || state == DRAIN) && (row == '0) && (v != '0)
                     && (dist_in < best_sad);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            v        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ref_addr <= '0;
            s1_addr  <= '0;
            s2_addr  <= '0;
            s1s2_sel <= '0;
            new_dist <= '0;
            dist_sel <= '0;
            best_dx  <= '0;
            best_dy  <= '0;
            best_sad <= '0;
        end else begin
            state    <= nxt_state;
            col      <= nxt_col;
            row      <= nxt_row;
            v        <= nxt_v;
            busy     <= (nxt_state == RUN) || (nxt_state == DRAIN);
            done     <= (nxt_state == DONE);
            ref_addr <= n_ref;
            s1_addr  <= n_s1;
            s2_addr  <= n_s2;
            s1s2_sel <= n_sel;
            new_dist <= n_nd;
            dist_sel <= n_ds;
            if (state == IDLE && start) begin
                best_dx  <= '0;
                best_dy  <= '0;
                best_sad <= '1;
            end else if (capture) begin
                best_dx  <= col;
                best_dy  <= v_m1[DYW-1:0];
                best_sad <= dist_in;
            end
        end
    end
endmodule

// File: tb/tb_me_schedule.sv
// tb/tb_me_schedule.sv - scoreboard bench for me_schedule with randomized distortion tables
module tb_me_schedule;
    localparam int N = 4;
    localparam int V = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [3:0]  ref_addr;
    logic [5:0]  s1_addr, s2_addr;
    logic [3:0]  s1s2_sel, new_dist;
    logic [1:0]  dist_sel, best_dx, best_dy;
    logic [15:0] dist_in = '0;
    logic [15:0] best_sad;

    me_schedule #(.N(N), .V(V), .DW(16)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .ref_addr(ref_addr), .s1_addr(s1_addr), .s2_addr(s2_addr),
        .s1s2_sel(s1s2_sel), .new_dist(new_dist), .dist_sel(dist_sel),
        .dist_in(dist_in), .best_dx(best_dx), .best_dy(best_dy), .best_sad(best_sad)
    );

    always #5 clock = ~clock;

    int          vectors = 0;
    int          miscompares = 0;
    int          ndone = 0;
    int          mon_cyc = 0;
    int          drv_cyc = 0;
    logic        rst_q = 1'b1;
    logic [15:0] cand [N][V];
    logic [25:0] exp_sched [$];
    logic [19:0] exp_best [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [25:0] exp_tuple(input int pv, input int row, input int col, input bit drain);
        logic [3:0] r, sel, nd;
        logic [5:0] a1, a2;
        logic [1:0] ds;
        int sr;
        r  = 4'(row*N + col);
        a1 = drain ? 6'd0 : 6'((row + pv)*2*N + col);
        sr = (row > 0) ? row - 1 + pv : N + pv - 2;
        a2 = (pv == 0 && row == 0) ? 6'd0 : 6'(sr*2*N + col + N);
        for (int k = 0; k < N; k++) sel[k] = (col < k);
        nd = (row == 0) ? 4'(1 << col) : 4'd0;
        ds = 2'(col);
        return {r, a1, a2, sel, nd, ds};
    endfunction

    always @(posedge clock) rst_q <= reset;

    // supplies each PE's sum on capture cycles and junk everywhere else
    always @(negedge clock) begin
        if (busy) begin
            int pv, row, col;
            pv  = drv_cyc / (N*N);
            row = (drv_cyc % (N*N)) / N;
            col = drv_cyc % N;
            if (row == 0 && pv >= 1) dist_in = cand[col][pv-1];
            else                     dist_in = 16'($urandom);
            drv_cyc++;
        end else begin
            drv_cyc = 0;
            dist_in = 16'($urandom);
        end
    end

    always @(negedge clock) begin
        logic [25:0] act;
        act = {ref_addr, s1_addr, s2_addr, s1s2_sel, new_dist, dist_sel};
        if (rst_q) begin
            chk("reset_outputs", {busy, done, ref_addr, s1_addr, s2_addr, s1s2_sel, new_dist,
                                  dist_sel, best_dx, best_dy, best_sad}, 64'd0);
            mon_cyc = 0;
        end else if (busy) begin
            if (done) chk("done_while_busy", 1, 0);
            if (exp_sched.size() == 0) chk("extra_busy_cycle", 1, 0);
            else chk("schedule", act, exp_sched.pop_front());
            if (mon_cyc == 25) chk("spot_v1_t9", act, {4'd9, 6'd25, 6'd21, 4'b1100, 4'b0000, 2'd1});
            if (mon_cyc == 33) chk("spot_v2_t1", act, {4'd1, 6'd17, 6'd37, 4'b1100, 4'b0010, 2'd1});
            if (mon_cyc == 64) chk("spot_drain0", act, {4'd0, 6'd0, 6'd52, 4'b1110, 4'b0001, 2'd0});
            mon_cyc++;
        end else begin
            chk("idle_outputs_zero", act, 64'd0);
            if (done) begin
                chk("busy_length", mon_cyc, V*N*N + N);
                chk("schedule_leftover", exp_sched.size(), 0);
                if (exp_best.size() == 0) chk("unexpected_done", 1, 0);
                else chk("best_result", {best_dx, best_dy, best_sad}, exp_best.pop_front());
                ndone++;
            end
            mon_cyc = 0;
        end
    end

    task automatic run_search(input bit abort);
        logic [15:0] b;
        logic [1:0]  bx, by;
        int          d0;
        bit          seen;
        b = 16'hFFFF; bx = 0; by = 0;
        for (int dy = 0; dy < V; dy++)
            for (int dx = 0; dx < N; dx++)
                if (cand[dx][dy] < b) begin b = cand[dx][dy]; bx = 2'(dx); by = 2'(dy); end
        for (int pv = 0; pv < V; pv++)
            for (int row = 0; row < N; row++)
                for (int col = 0; col < N; col++)
                    exp_sched.push_back(exp_tuple(pv, row, col, 1'b0));
        for (int col = 0; col < N; col++) exp_sched.push_back(exp_tuple(V, 0, col, 1'b1));
        exp_best.push_back({bx, by, b});
        d0 = ndone;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        if (abort) begin
            repeat (18) @(negedge clock);
            reset = 1'b1;
            @(posedge clock);
            exp_sched.delete();
            exp_best.delete();
            repeat (2) @(negedge clock);
            reset = 1'b0;
            repeat (6) @(negedge clock);
            chk("no_done_after_reset", ndone, d0);
        end else begin
            repeat (10) @(negedge clock);
            start = 1'b1;
            @(negedge clock) start = 1'b0;
            seen = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clock);
                if (ndone != d0) seen = 1;
            end
            if (!seen) chk("done_timeout", 0, 1);
            repeat (3) @(negedge clock);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        for (int dx = 0; dx < N; dx++) for (int dy = 0; dy < V; dy++) cand[dx][dy] = 16'd100;
        cand[2][3] = 16'd7;
        run_search(1'b0);

        for (int dx = 0; dx < N; dx++) for (int dy = 0; dy < V; dy++) cand[dx][dy] = 16'd50;
        run_search(1'b0);

        for (int dx = 0; dx < N; dx++) for (int dy = 0; dy < V; dy++) cand[dx][dy] = 16'hFFFF;
        run_search(1'b0);

        for (int dx = 0; dx < N; dx++) for (int dy = 0; dy < V; dy++) cand[dx][dy] = 16'($urandom);
        run_search(1'b1);

        for (int r = 0; r < 6; r++) begin
            for (int dx = 0; dx < N; dx++)
                for (int dy = 0; dy < V; dy++)
                    cand[dx][dy] = (r < 3) ? 16'($urandom_range(0, 12)) : 16'($urandom);
            run_search(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/me_schedule.md
# me_schedule

Sequencing controller for the 1-D systolic full-search motion-estimation array of N `processing_element` instances. For each vertical displacement it drives reference/search memory addresses, the per-PE `s1s2_mux` selects and `new_dist` clears. It reads each PE's finished accumulated distortion through a shared result bus and tracks the minimum-distortion motion vector. One `start` runs one complete block search and ends with a `done` pulse.

## Interface
- N, 4, block size (N×N pixels) = number of PEs = horizontal displacements 0..N-1
- V, 4, vertical displacements 0..V-1
- DW, 16, distortion width of `accumulate`/`dist_in`
- RAW, $clog2(N*N), reference memory address width
- SAW, $clog2((N+V-1)*2*N), search memory address width (window: N+V-1 rows × 2N columns, row-major)

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request; ignored unless idle
- busy  out  1  high while the schedule runs
- done  out  1  one-cycle pulse; results valid
- ref_addr  out  RAW  reference pixel address, row*N+col
- s1_addr  out  SAW  search address feeding the PE `s1` bus
- s2_addr  out  SAW  search address feeding the PE `s2` bus
- s1s2_sel  out  N  bit k drives PE k `s1s2_mux` (1 = take s2)
- new_dist  out  N  bit k drives PE k `new_dist`
- dist_sel  out  $clog2(N)  index of the PE whose `accumulate` is muxed onto dist_in
- dist_in  in  DW  selected PE accumulator (combinational mux outside)
- best_dx  out  $clog2(N)  winning horizontal displacement
- best_dy  out  $clog2(V)  winning vertical displacement
- best_sad  out  DW  winning distortion

## Operation
- States: IDLE, RUN, DRAIN, DONE. IDLE→RUN on `start` while idle; RUN→DRAIN after the last cycle of pass V-1; DRAIN→DONE after N cycles; DONE→IDLE unconditionally.
- RUN: passes v = 0..V-1, each N*N schedule cycles t = row*N+col, with col fastest. Passes are back to back, with no gap.
- Per schedule cycle, all from registers:
  - ref_addr = row*N+col.
  - s1_addr = (row+v)*2N + col.
  - s2_addr = srow*2N + col + N, where srow = row-1+v if row>0, else N+v-2. For v=0, row=0, s2_addr = 0.
  - s1s2_sel[k] = (col < k).
  - new_dist[k] = (row==0 && col==k).
  - dist_sel = col.
- DRAIN: N cycles with row=0, v=V, col=0..N-1, and the same formulas. s1_addr is forced to 0.
- Capture: in every cycle with row==0 and v≥1 (including DRAIN), dist_in holds PE col's sum for (dx=col, dy=v-1). The block compares it at the closing edge.
- Minimum rule: replace the best values only if dist_in < best_sad (strict, unsigned). Ties keep the earlier candidate, i.e. the lower dy, then the lower dx.
- On accepted `start`, best_sad is set to all-ones and best_dx/best_dy to 0.
- `start` is ignored during RUN, DRAIN and DONE.
- Reset, including mid-operation, returns the block to IDLE on the next edge. No `done` is produced.

## Timing
- Reset values:
  - busy, done, ref_addr, s1_addr, s2_addr, s1s2_sel, new_dist, dist_sel, best_dx, best_dy = 0.
  - best_sad = 0.
- IDLE/DONE: all address, select and new_dist outputs are 0.
- `start` sampled at edge E0 → schedule cycle 0 is presented in the cycle after E0, with busy=1.
- busy stays high for exactly V*N*N + N cycles.
- done=1 in the single cycle following the last DRAIN cycle. busy=0 in that cycle.
- best_* update one edge after their capture cycle. They are final when done=1 and hold until the next accepted start.
- Address outputs are valid in the same cycle as the matching sel/new_dist. The datapath consumes them at the closing edge.
- Wrap-around: col N-1→0 increments row; row N-1→0 increments v. v=V-1 end → DRAIN with col=0.

## Test plan
- Reset: assert reset 2 cycles mid-run → every output 0 next cycle, busy=0, no done; later `start` runs normally.
- Schedule length (N=4, V=4): start pulse → busy high exactly 68 cycles, done high in cycle 69 for one cycle only; second start during busy has no effect.
- Address/select check in pass v=1, t=9 (row 2, col 1) → ref_addr=9, s1_addr=25, s2_addr=21, s1s2_sel=4'b1100, new_dist=4'b0000, dist_sel=1.
- Pass-boundary check in pass v=2, t=1 (row 0, col 1) → new_dist=4'b0010, dist_sel=1, s2_addr=(4+2-2)*8+1+4=37.
- Minimum search: bench returns dist_in=100 for all candidates except (dx=2, dy=3)=7, the latter captured during DRAIN → best_dx=2, best_dy=3, best_sad=7 at done.
- Ties: dist_in=50 constant → best_dx=0, best_dy=0, best_sad=50; all-ones input at every capture → best_sad stays all-ones, dx=dy=0.
